// File: rtl/add_round_key_engine.sv
// Sequential AddRoundKey stage: a writable round-key bank and a round counter
// that steps in encrypt or decrypt order, with a one-deep valid/ready output register.
module add_round_key_engine #(
    parameter int STATE_W  = 64,
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               keyWrEn,
    input  logic [IDX_W-1:0]   keyWrIdx,
    input  logic [STATE_W-1:0] keyWrData,
    input  logic               roundRst,
    input  logic               decrypt,
    input  logic               inValid,
    output logic               inReady,
    input  logic [STATE_W-1:0] currentState,
    output logic               outValid,
    input  logic               outReady,
    output logic [STATE_W-1:0] nextState,
    output logic [IDX_W-1:0]   outRoundIdx,
    output logic               outLast
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    logic [STATE_W-1:0] key_bank [NUM_KEYS];
    logic [IDX_W-1:0]   rnd;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   end_idx;
    logic [IDX_W-1:0]   step_idx;
    logic               mode_dec;
    logic               eff_dec;
    logic               accept;
    logic               wr_ok;

    assign inReady = !outValid || outReady;
    assign accept  = inValid && inReady;
    assign wr_ok   = keyWrEn && ({1'b0, keyWrIdx} < (IDX_W + 1)'(NUM_KEYS));

    // A roundRst in the same cycle overrides both the stored mode and the counter.
    always_comb begin
        eff_dec = roundRst ? decrypt : mode_dec;
        idx     = roundRst ? (decrypt ? LAST_IDX : '0) : rnd;
        end_idx = eff_dec ? '0 : LAST_IDX;
        if (idx == end_idx) begin
            step_idx = eff_dec ? LAST_IDX : '0;
        end else if (eff_dec) begin
            step_idx = idx - IDX_W'(1);
        end else begin
            step_idx = idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_bank[i] <= '0;
            end
        end else if (wr_ok) begin
            key_bank[keyWrIdx] <= keyWrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd      <= '0;
            mode_dec <= 1'b0;
        end else if (accept || roundRst) begin
            mode_dec <= eff_dec;
            rnd      <= accept ? step_idx : idx;
        end
    end

    // The XOR reads the key bank before this edge's write lands, so a
    // same-slot write is only seen by later words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid    <= 1'b0;
            nextState   <= '0;
            outRoundIdx <= '0;
            outLast     <= 1'b0;
        end else if (accept) begin
            outValid    <= 1'b1;
            nextState   <= currentState ^ key_bank[idx];
            outRoundIdx <= idx;
            outLast     <= (idx == end_idx);
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_round_key_engine.sv
// Directed bench for add_round_key_engine: a default 4-key/64-bit instance and
// a 3-key/16-bit instance for the non-power-of-two key bank.
module tb_add_round_key_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_keyWrEn, a_roundRst, a_decrypt, a_inValid, a_inReady;
    logic        a_outValid, a_outReady, a_outLast;
    logic [1:0]  a_keyWrIdx, a_outRoundIdx;
    logic [63:0] a_keyWrData, a_currentState, a_nextState;

    logic        b_keyWrEn, b_roundRst, b_decrypt, b_inValid, b_inReady;
    logic        b_outValid, b_outReady, b_outLast;
    logic [1:0]  b_keyWrIdx, b_outRoundIdx;
    logic [15:0] b_keyWrData, b_currentState, b_nextState;

    add_round_key_engine #(.STATE_W(64), .NUM_KEYS(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .keyWrEn(a_keyWrEn), .keyWrIdx(a_keyWrIdx), .keyWrData(a_keyWrData),
        .roundRst(a_roundRst), .decrypt(a_decrypt),
        .inValid(a_inValid), .inReady(a_inReady), .currentState(a_currentState),
        .outValid(a_outValid), .outReady(a_outReady), .nextState(a_nextState),
        .outRoundIdx(a_outRoundIdx), .outLast(a_outLast)
    );

    add_round_key_engine #(.STATE_W(16), .NUM_KEYS(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .keyWrEn(b_keyWrEn), .keyWrIdx(b_keyWrIdx), .keyWrData(b_keyWrData),
        .roundRst(b_roundRst), .decrypt(b_decrypt),
        .inValid(b_inValid), .inReady(b_inReady), .currentState(b_currentState),
        .outValid(b_outValid), .outReady(b_outReady), .nextState(b_nextState),
        .outRoundIdx(b_outRoundIdx), .outLast(b_outLast)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic checkA(input string tag, input logic valid, input logic [63:0] state,
                          input logic [1:0] idx, input logic last);
        checkOutput({tag, ".outValid"}, 64'(a_outValid), 64'(valid));
        checkOutput({tag, ".nextState"}, a_nextState, state);
        checkOutput({tag, ".outRoundIdx"}, 64'(a_outRoundIdx), 64'(idx));
        checkOutput({tag, ".outLast"}, 64'(a_outLast), 64'(last));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [63:0] state);
        a_inValid      = valid;
        a_currentState = state;
    endtask

    task automatic loadKeyA(input logic [1:0] idx, input logic [63:0] data);
        a_keyWrEn = 1'b1; a_keyWrIdx = idx; a_keyWrData = data;
        tick;
        a_keyWrEn = 1'b0;
    endtask

    task automatic loadKeyB(input logic [1:0] idx, input logic [15:0] data);
        b_keyWrEn = 1'b1; b_keyWrIdx = idx; b_keyWrData = data;
        tick;
        b_keyWrEn = 1'b0;
    endtask

    logic [63:0] encExp [5] = '{64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                                 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};
    logic [1:0]  encIdx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic        encLast[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] decExp [4] = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA,
                                 64'h5555AAAA5555AAAA};
    logic [1:0]  decIdx [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic        decLast[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] bExp   [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0001};
    logic [1:0]  bIdx   [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic        bLast  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        a_keyWrEn = 0; a_keyWrIdx = 0; a_keyWrData = 0; a_roundRst = 0; a_decrypt = 0;
        a_outReady = 1; applyStimulus(1'b0, 64'h0);
        b_keyWrEn = 0; b_keyWrIdx = 0; b_keyWrData = 0; b_roundRst = 0; b_decrypt = 0;
        b_outReady = 1; b_inValid = 0; b_currentState = 0;

        #2;
        checkA("reset", 1'b0, 64'h0, 2'd0, 1'b0);
        checkOutput("reset.inReady", 64'(a_inReady), 64'd1);
        #1 rst_n = 1'b1;

        loadKeyA(2'd0, 64'h0F1E2D3C4B5A6978);
        applyStimulus(1'b1, 64'h123456789ABCDEF0);
        tick;
        checkA("firstXor", 1'b1, 64'h1D2A7B44D1E6B788, 2'd0, 1'b0);
        applyStimulus(1'b0, 64'h0);

        rst_n = 1'b0;
        #1;
        checkA("midReset", 1'b0, 64'h0, 2'd0, 1'b0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) loadKeyA(2'(i), 64'h5555555555555555 * i);
        applyStimulus(1'b1, 64'hAAAAAAAAAAAAAAAA);
        for (int i = 0; i < 5; i++) begin
            tick;
            checkA($sformatf("enc%0d", i), 1'b1, encExp[i], encIdx[i], encLast[i]);
        end
        applyStimulus(1'b0, 64'h0);
        tick;
        checkOutput("encDrain.outValid", 64'(a_outValid), 64'd0);

        loadKeyA(2'd3, 64'hFFFF0000FFFF0000);
        a_roundRst = 1; a_decrypt = 1;
        applyStimulus(1'b1, 64'h0000FFFF0000FFFF);
        tick;
        checkA("dec0", 1'b1, 64'hFFFFFFFFFFFFFFFF, 2'd3, 1'b0);
        a_roundRst = 0; a_decrypt = 0;
        applyStimulus(1'b1, 64'hAAAAAAAAAAAAAAAA);
        for (int i = 0; i < 4; i++) begin
            tick;
            checkA($sformatf("dec%0d", i + 1), 1'b1, decExp[i], decIdx[i], decLast[i]);
        end

        applyStimulus(1'b1, 64'h1111111111111111);
        tick;
        checkA("bpFirst", 1'b1, 64'hBBBBBBBBBBBBBBBB, 2'd2, 1'b0);
        a_outReady = 0;
        applyStimulus(1'b1, 64'h2222222222222222);
        #1;
        checkOutput("bpStall.inReady", 64'(a_inReady), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkA($sformatf("bpHold%0d", i), 1'b1, 64'hBBBBBBBBBBBBBBBB, 2'd2, 1'b0);
            checkOutput($sformatf("bpHold%0d.inReady", i), 64'(a_inReady), 64'd0);
        end
        a_outReady = 1;
        #1;
        checkOutput("bpRelease.inReady", 64'(a_inReady), 64'd1);
        tick;
        checkA("bpResume0", 1'b1, 64'h7777777777777777, 2'd1, 1'b0);
        applyStimulus(1'b1, 64'h3333333333333333);
        tick;
        checkA("bpResume1", 1'b1, 64'h3333333333333333, 2'd0, 1'b1);
        applyStimulus(1'b0, 64'h0);
        tick;
        checkOutput("bpDrain.outValid", 64'(a_outValid), 64'd0);

        a_keyWrEn = 1; a_keyWrIdx = 2'd0; a_keyWrData = 64'hFFFFFFFFFFFFFFFF;
        a_roundRst = 1; a_decrypt = 0;
        applyStimulus(1'b1, 64'h0);
        tick;
        checkA("sameCycleWr", 1'b1, 64'h0, 2'd0, 1'b0);
        a_keyWrEn = 0;
        tick;
        checkA("newKeyUse", 1'b1, 64'hFFFFFFFFFFFFFFFF, 2'd0, 1'b0);
        a_roundRst = 0;
        applyStimulus(1'b0, 64'h0);

        loadKeyB(2'd0, 16'h0001);
        loadKeyB(2'd1, 16'h0002);
        loadKeyB(2'd2, 16'h0004);
        loadKeyB(2'd3, 16'hFFFF);
        b_inValid = 1; b_currentState = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput($sformatf("keys3_%0d.nextState", i), 64'(b_nextState), 64'(bExp[i]));
            checkOutput($sformatf("keys3_%0d.outRoundIdx", i), 64'(b_outRoundIdx), 64'(bIdx[i]));
            checkOutput($sformatf("keys3_%0d.outLast", i), 64'(b_outLast), 64'(bLast[i]));
        end
        b_inValid = 0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/add_round_key_engine.md
# add_round_key_engine

Sequential, parametrised AddRoundKey stage for the Simplified-AES datapath. It holds a bank of NUM_KEYS round keys loaded through a write port. Each state word accepted on a valid/ready input is XORed with the round key selected by an internal round counter, which steps in encrypt (ascending) or decrypt (descending) order. Results leave through a one-deep registered valid/ready output stage. It sits between the key-expansion logic and the round datapath, and replaces the purely combinational AddRoundKey.

## Interface
- STATE_W, 64, state and round-key width in bits (multiple of 4, ≥ 16)
- NUM_KEYS, 4, number of stored round keys (≥ 2)
- IDX_W, $clog2(NUM_KEYS), key index width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- keyWrEn  in  1  write keyWrData into slot keyWrIdx
- keyWrIdx  in  IDX_W  key slot; writes with index ≥ NUM_KEYS are ignored
- keyWrData  in  STATE_W  round key value
- roundRst  in  1  restart the round sequence and latch decrypt
- decrypt  in  1  0 = ascending key order, 1 = descending; sampled only with roundRst
- inValid  in  1  currentState valid
- inReady  out  1  stage can accept
- currentState  in  STATE_W  state word in
- outValid  out  1  nextState valid
- outReady  in  1  downstream accepts
- nextState  out  STATE_W  currentState XOR selected round key
- outRoundIdx  out  IDX_W  key index used for nextState
- outLast  out  1  nextState used the final key of the sequence

## Operation
- Key bank: NUM_KEYS × STATE_W registers, written on clk when keyWrEn=1.
- Round counter `rnd` and latched mode `modeDec`.
- Start index is 0 when encrypting and NUM_KEYS-1 when decrypting.
- Accept occurs when inValid && inReady.
- On accept, register:
  - nextState = currentState ^ key[idx]
  - outRoundIdx = idx
  - outLast = (idx == end index), where end is NUM_KEYS-1 for encrypt and 0 for decrypt
  - set outValid = 1
- idx is rnd, except when roundRst is high in the same cycle, in which case idx is the start index of the new mode (from the decrypt input).
- After an accept, rnd steps by +1 (encrypt) or -1 (decrypt). It wraps from the end index back to the start index.
- roundRst without accept: rnd = start(decrypt), modeDec = decrypt.
- roundRst with accept: the block uses start(decrypt) and rnd becomes start(decrypt) ± 1.
- Key write and read of the same slot in one cycle: the XOR uses the old key value. The new value is visible from the next cycle.
- Output stage:
  - inReady = !outValid || outReady (combinational; no bubble under continuous flow).
  - outValid clears when outValid && outReady && no accept in that cycle.
  - While outValid && !outReady, nextState, outRoundIdx and outLast hold stable.
- No arithmetic beyond bitwise XOR and index ±1 mod NUM_KEYS. Widths are exact and nothing is truncated.

## Timing
- Reset values (rst_n low, immediately, independent of clk):
  - all key slots = 0, rnd = 0, modeDec = 0
  - outValid = 0, nextState = 0, outRoundIdx = 0, outLast = 0
  - inReady = 1 once out of reset, because outValid = 0
- Reset released mid-sequence: the sequence restarts at index 0 in encrypt mode, and all keys must be reloaded.
- Latency is 1 cycle from accept to outValid. Throughput is 1 word per cycle while outReady=1.
- Backpressure: inReady falls in the same cycle that outValid=1 and outReady=0. No input is lost or duplicated.
- roundRst takes effect for the accept in the same cycle. decrypt is ignored in cycles without roundRst.

## Test plan
- Reset and keys:
  - Assert rst_n low mid-stream -> all outputs drop to 0 without a clock edge.
  - Write key0 = 0x0F1E2D3C4B5A6978, then accept 0x123456789ABCDEF0 -> next cycle nextState = 0x1D2A7B44D1E6B788, outRoundIdx = 0, outLast = 0.
- Encrypt sweep with outReady=1:
  - Load keys 0..3 = 0x5555555555555555 × i (i = 0..3).
  - Send 5 back-to-back words of 0xAAAAAAAAAAAAAAAA.
  - -> idx sequence 0,1,2,3,0; outLast only on the 4th output; one output per cycle.
- Decrypt:
  - Pulse roundRst with decrypt=1 together with the first accept.
  - -> idx sequence 3,2,1,0,3; outLast on idx 0; a word with key3 = 0xFFFF0000FFFF0000 and input 0x0000FFFF0000FFFF gives 0xFFFFFFFFFFFFFFFF.
- Backpressure:
  - Hold outReady=0 for 3 cycles with inValid=1.
  - -> inReady = 0, output held stable, rnd does not advance; on release, words resume in order with no loss.
- Same-cycle key write:
  - Rewrite slot 0 with 0xFFFFFFFFFFFFFFFF while accepting 0x0000000000000000 at idx 0 (old key 0).
  - -> nextState = 0; the next use of idx 0 gives 0xFFFFFFFFFFFFFFFF.
- Out-of-range write:
  - With NUM_KEYS = 3 and IDX_W = 2, write keyWrIdx = 3.
  - -> no slot changes; the encrypt sequence wraps 0,1,2,0.
